reduction_mux_sched: RTL and testbench
======================================

# reduction_mux_sched

Sequencer that drives the select inputs of the unstructured-sparsity reduction mux. It accepts one NUM_IN-bit nonzero mask per operand group and issues one beat per cycle, each beat naming up to two nonzero lane indices (`left` = lower index, `right` = higher index). A group's nonzeros are compacted into ceil(popcount/2) beats, which lets the downstream 2-wide reduction datapath skip zero operands.

## Interface
- `NUM_IN`, 4, number of mux input lanes; power of two, ≥2
- `SEL_IN`, 2, index width; must equal log2(NUM_IN)
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — synchronous, active-high reset
- `mask_valid` input 1 — a new nonzero mask is offered
- `mask_ready` output 1 — the scheduler can accept a mask
- `mask` input NUM_IN — bit i set = lane i nonzero
- `sel_valid` output 1 — a beat is presented
- `sel_ready` input 1 — the datapath consumes the beat
- `sel` output 2*SEL_IN — packed as {right, left}; feeds the mux select directly
- `pair_mask` output 2 — bit0 = left lane valid, bit1 = right lane valid
- `last` output 1 — final beat of the current mask
- `busy` output 1 — high whenever the FSM is in ISSUE

## Operation
- FSM states: IDLE, ISSUE.
- IDLE:
  - `mask_ready` = 1.
  - On `mask_valid & mask_ready`, register the mask into `pend` and go to ISSUE.
  - Load the first beat into the output registers on the same edge.
- ISSUE:
  - A beat completes on `sel_valid & sel_ready`.
  - On completion, clear the two emitted bits from `pend` and load the next beat.
  - If the completing beat has `last` = 1, return to IDLE instead.
- Beat formation from the remaining mask R:
  - `left` = lowest set bit of R.
  - `right` = next-lowest set bit of R.
  - `last` = 1 when popcount(R) ≤ 2.
- One bit remaining: `right` = 0, `pair_mask` = 01.
- Empty mask (all zeros): exactly one beat with `sel` = 0, `pair_mask` = 00, `last` = 1. This keeps the downstream accumulator beat-aligned.
- While `sel_valid & !sel_ready`, `sel`, `pair_mask` and `last` hold stable (standard valid/ready stall).
- `mask` is sampled only on the accepting edge. Later changes to `mask` have no effect on the beats in progress.

## Timing
- Reset values: `sel_valid` 0, `sel` 0, `pair_mask` 00, `last` 0, `busy` 0, FSM IDLE.
- While `rst` is high, `mask_ready` = 0. It rises in the first cycle after reset deasserts.
- Latency: mask accepted at edge N; the first beat is valid in the cycle after edge N.
- All beat outputs are registered. `mask_ready` is combinational from FSM state (plus `sel_ready` when overlap is enabled).
- Throughput: ceil(popcount/2) beats per mask (minimum 1).
  - Without overlap: one idle cycle between masks.
- Reset mid-operation: the pending mask is discarded, `sel_valid` drops on the next edge, and no `last` is ever emitted for the aborted group.
- Simultaneous `mask_valid` and completion of a final beat: the mask is accepted only when overlap is enabled (see Configuration). Otherwise it waits for IDLE.

## Configuration
- Macro `REDUCTION_SCHED_OVERLAP_EN`.
- Defined:
  - `mask_ready` = IDLE | (`sel_valid & last & sel_ready`).
  - A mask accepted on a final-beat edge loads its first beat on that same edge, and the FSM stays in ISSUE.
  - Zero-bubble back-to-back groups.
- Undefined: `mask_ready` = IDLE only, giving one bubble cycle per group.

## Structure
- Shared package `reduction_pkg` holds:
  - state enum `red_sched_state_t` {IDLE, ISSUE};
  - `localparam` `RED_PAIR_W` = 2;
  - a function `popcnt_le2` on a NUM_IN-bit vector.
- One sub-module, `pair_pick_enc`: combinational lowest-two priority encoder.
  - Input: the NUM_IN-bit mask.
  - Outputs: `left`, `right`, `pair_mask`, `last`, and the residual mask.
  - Used on both the load path and the advance path.

## Test plan
- Mask 4'b1011, `sel_ready` = 1 → two beats:
  - beat 1: `sel` = {1,0}, `pair_mask` = 11, `last` = 0;
  - beat 2: `sel` = {0,3}, `pair_mask` = 01, `last` = 1.
  - Then IDLE.
- Mask 4'b0000 → one beat: `sel` = 0, `pair_mask` = 00, `last` = 1.
- Mask 4'b1111, `sel_ready` held low 3 cycles on beat 1 → `sel` = {1,0} held stable for those cycles; then beat 2 `sel` = {3,2}, `last` = 1.
- Masks 4'b0110 then 4'b1000 offered back-to-back:
  - with `REDUCTION_SCHED_OVERLAP_EN` → beats on consecutive cycles ({2,1} then {0,3}), with no gap;
  - without it → exactly one `sel_valid` = 0 cycle between them.
- `rst` asserted during beat 1 of mask 4'b1111 → the next cycle has `sel_valid` = 0, `busy` = 0 and all outputs at reset values, and no `last` is seen.

Source files
------------

// File: rtl/reduction_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reduction_pkg
// Brief    : Shared types, constants and helpers for the reduction mux scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package reduction_pkg;

  localparam int RED_PAIR_W = 2;
  // Widest mask popcnt_le2 accepts; narrower masks are zero-extended by callers.
  localparam int RED_MAX_IN = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } red_sched_state_t;

  // Clearing the lowest set bit twice leaves zero iff at most two bits were set.
  function automatic logic popcnt_le2(input logic [RED_MAX_IN-1:0] v);
    logic [RED_MAX_IN-1:0] r;
    r = v & (v - RED_MAX_IN'(1));
    r = r & (r - RED_MAX_IN'(1));
    return (r == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pair_pick_enc.sv
`default_nettype none
// ============================================================================
// Module   : pair_pick_enc
// Brief    : Combinational lowest-two priority encoder with residual mask.
// Revision : 1.0 - initial release
// ============================================================================
module pair_pick_enc
  import reduction_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_IN = 2
) (
  input  logic [NUM_IN-1:0]     mask,
  output logic [SEL_IN-1:0]     left,
  output logic [SEL_IN-1:0]     right,
  output logic [RED_PAIR_W-1:0] pair_mask,
  output logic                  last,
  output logic [NUM_IN-1:0]     residual
);

  logic [NUM_IN-1:0] w_rest1;
  logic [NUM_IN-1:0] w_rest2;

  assign w_rest1 = mask & (mask - NUM_IN'(1));
  assign w_rest2 = w_rest1 & (w_rest1 - NUM_IN'(1));

  // Scan downward so the lowest set bit is the final assignment.
  always_comb begin
    left  = '0;
    right = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (mask[i]) left = SEL_IN'(i);
      if (w_rest1[i]) right = SEL_IN'(i);
    end
  end

  assign pair_mask = {|w_rest1, |mask};
  assign last      = popcnt_le2(RED_MAX_IN'(mask));
  assign residual  = w_rest2;

endmodule
`default_nettype wire

// File: rtl/reduction_mux_sched.sv
`default_nettype none
// ============================================================================
// Module   : reduction_mux_sched
// Brief    : Issues compacted {right,left} lane-pair beats per nonzero mask.
// Config   : REDUCTION_SCHED_OVERLAP_EN - accept next mask on final-beat edge.
// Revision : 1.0 - initial release
// ============================================================================
module reduction_mux_sched
  import reduction_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int SEL_IN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mask_valid,
  output logic                  mask_ready,
  input  logic [NUM_IN-1:0]     mask,
  output logic                  sel_valid,
  input  logic                  sel_ready,
  output logic [2*SEL_IN-1:0]   sel,
  output logic [RED_PAIR_W-1:0] pair_mask,
  output logic                  last,
  output logic                  busy
);

  red_sched_state_t r_state, w_state_nxt;

  // r_pend holds lanes not yet presented (excludes the beat on the outputs).
  logic [NUM_IN-1:0]     r_pend,      w_pend_nxt;
  logic                  r_sel_valid, w_sel_valid_nxt;
  logic [2*SEL_IN-1:0]   r_sel,       w_sel_nxt;
  logic [RED_PAIR_W-1:0] r_pair_mask, w_pair_mask_nxt;
  logic                  r_last,      w_last_nxt;

  logic [SEL_IN-1:0]     w_ld_left, w_ld_right, w_av_left, w_av_right;
  logic [RED_PAIR_W-1:0] w_ld_pair_mask, w_av_pair_mask;
  logic                  w_ld_last, w_av_last;
  logic [NUM_IN-1:0]     w_ld_residual, w_av_residual;

  logic w_idle, w_complete, w_overlap, w_accept;

  pair_pick_enc #(.NUM_IN(NUM_IN), .SEL_IN(SEL_IN)) u_enc_load (
    .mask      (mask),
    .left      (w_ld_left),
    .right     (w_ld_right),
    .pair_mask (w_ld_pair_mask),
    .last      (w_ld_last),
    .residual  (w_ld_residual)
  );

  pair_pick_enc #(.NUM_IN(NUM_IN), .SEL_IN(SEL_IN)) u_enc_adv (
    .mask      (r_pend),
    .left      (w_av_left),
    .right     (w_av_right),
    .pair_mask (w_av_pair_mask),
    .last      (w_av_last),
    .residual  (w_av_residual)
  );

  assign w_idle     = (r_state == IDLE);
  assign w_complete = r_sel_valid & sel_ready;

`ifdef REDUCTION_SCHED_OVERLAP_EN
  assign w_overlap = r_sel_valid & r_last & sel_ready;
`else
  assign w_overlap = 1'b0;
`endif

  assign mask_ready = ~rst & (w_idle | w_overlap);
  assign w_accept   = mask_valid & mask_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_nxt      = r_pend;
    w_sel_valid_nxt = r_sel_valid;
    w_sel_nxt       = r_sel;
    w_pair_mask_nxt = r_pair_mask;
    w_last_nxt      = r_last;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt     = ISSUE;
          w_pend_nxt      = w_ld_residual;
          w_sel_valid_nxt = 1'b1;
          w_sel_nxt       = {w_ld_right, w_ld_left};
          w_pair_mask_nxt = w_ld_pair_mask;
          w_last_nxt      = w_ld_last;
        end
      end
      ISSUE: begin
        if (w_complete) begin
          if (r_last && w_accept) begin
            w_pend_nxt      = w_ld_residual;
            w_sel_nxt       = {w_ld_right, w_ld_left};
            w_pair_mask_nxt = w_ld_pair_mask;
            w_last_nxt      = w_ld_last;
          end else if (r_last) begin
            w_state_nxt     = IDLE;
            w_pend_nxt      = '0;
            w_sel_valid_nxt = 1'b0;
            w_sel_nxt       = '0;
            w_pair_mask_nxt = '0;
            w_last_nxt      = 1'b0;
          end else begin
            w_pend_nxt      = w_av_residual;
            w_sel_nxt       = {w_av_right, w_av_left};
            w_pair_mask_nxt = w_av_pair_mask;
            w_last_nxt      = w_av_last;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_sel_valid <= 1'b0;
      r_sel       <= '0;
      r_pair_mask <= '0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_sel_valid <= w_sel_valid_nxt;
      r_sel       <= w_sel_nxt;
      r_pair_mask <= w_pair_mask_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign sel_valid = r_sel_valid;
  assign sel       = r_sel;
  assign pair_mask = r_pair_mask;
  assign last      = r_last;
  assign busy      = (r_state == ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_reduction_mux_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduction_mux_sched
// Brief    : Directed and random checks of reduction_mux_sched beat sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reduction_mux_sched;

  localparam int NUM_IN = 4;
  localparam int SEL_IN = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                mask_valid;
  logic                mask_ready;
  logic [NUM_IN-1:0]   mask;
  logic                sel_valid;
  logic                sel_ready;
  logic [2*SEL_IN-1:0] sel;
  logic [1:0]          pair_mask;
  logic                last;
  logic                busy;

  typedef struct {
    logic [2*SEL_IN-1:0] sel;
    logic [1:0]          pm;
    logic                last;
  } beat_t;

  beat_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  reduction_mux_sched #(.NUM_IN(NUM_IN), .SEL_IN(SEL_IN)) dut (
    .clk        (clk),
    .rst        (rst),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .mask       (mask),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel        (sel),
    .pair_mask  (pair_mask),
    .last       (last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: list nonzero lanes in ascending order and pair them up.
  function automatic void build(input logic [NUM_IN-1:0] m);
    int    idx[$];
    beat_t b;
    q.delete();
    for (int i = 0; i < NUM_IN; i++) if (m[i]) idx.push_back(i);
    if (idx.size() == 0) begin
      b.sel = '0; b.pm = 2'b00; b.last = 1'b1;
      q.push_back(b);
    end else begin
      for (int k = 0; k < idx.size(); k += 2) begin
        int l, r;
        l = idx[k];
        r = (k + 1 < idx.size()) ? idx[k+1] : 0;
        b.sel  = (2*SEL_IN)'((r << SEL_IN) + l);
        b.pm   = (k + 1 < idx.size()) ? 2'b11 : 2'b01;
        b.last = (k + 2 >= idx.size());
        q.push_back(b);
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input beat_t b, input string tag);
    chk({tag, "_valid"}, 32'(sel_valid), 32'd1);
    chk({tag, "_sel"},   32'(sel),       32'(b.sel));
    chk({tag, "_pm"},    32'(pair_mask), 32'(b.pm));
    chk({tag, "_last"},  32'(last),      32'(b.last));
    chk({tag, "_busy"},  32'(busy),      32'd1);
`ifndef REDUCTION_SCHED_OVERLAP_EN
    chk({tag, "_ready_low"}, 32'(mask_ready), 32'd0);
`endif
  endtask

  task automatic send(input logic [NUM_IN-1:0] m);
    int t;
    t = 0;
    mask       = m;
    mask_valid = 1'b1;
    while (!mask_ready && t < 20) begin
      step();
      t++;
    end
    chk("ready_wait", 32'(mask_ready), 32'd1);
    step();
    mask_valid = 1'b0;
    mask       = NUM_IN'($urandom);
  endtask

  task automatic run_group(input logic [NUM_IN-1:0] m, input int first_stall,
                           input int max_stall, input string tag);
    int st;
    build(m);
    send(m);
    for (int k = 0; k < q.size(); k++) begin
      st = (k == 0) ? first_stall : int'($urandom_range(max_stall, 0));
      sel_ready = 1'b0;
      repeat (st) begin
        check_beat(q[k], {tag, "_stall"});
        step();
      end
      sel_ready = 1'b1;
      check_beat(q[k], tag);
      step();
      sel_ready = 1'b0;
    end
    chk({tag, "_end_valid"}, 32'(sel_valid), 32'd0);
    chk({tag, "_end_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    beat_t b1, b2;
    rst        = 1'b1;
    mask_valid = 1'b0;
    sel_ready  = 1'b0;
    mask       = '0;
    repeat (3) step();
    chk("rst_valid", 32'(sel_valid),  32'd0);
    chk("rst_sel",   32'(sel),        32'd0);
    chk("rst_pm",    32'(pair_mask),  32'd0);
    chk("rst_last",  32'(last),       32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_ready", 32'(mask_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(mask_ready), 32'd1);
    step();

    run_group(4'b1011, 0, 0, "m1011");
    run_group(4'b0000, 0, 0, "m0000");
    run_group(4'b1111, 3, 0, "m1111");

    // Back-to-back masks with the consumer always ready.
    build(4'b0110); b1 = q[0];
    build(4'b1000); b2 = q[0];
    sel_ready  = 1'b1;
    mask       = 4'b0110;
    mask_valid = 1'b1;
    step();
    mask = 4'b1000;
    check_beat(b1, "b2b_first");
    step();
`ifdef REDUCTION_SCHED_OVERLAP_EN
    mask_valid = 1'b0;
    check_beat(b2, "b2b_second");
`else
    chk("b2b_gap_valid", 32'(sel_valid),  32'd0);
    chk("b2b_gap_ready", 32'(mask_ready), 32'd1);
    step();
    mask_valid = 1'b0;
    check_beat(b2, "b2b_second");
`endif
    step();
    chk("b2b_end_valid", 32'(sel_valid), 32'd0);
    sel_ready = 1'b0;

    // Reset during the first beat of a four-lane group.
    build(4'b1111);
    send(4'b1111);
    check_beat(q[0], "abort_beat");
    rst = 1'b1;
    step();
    chk("abort_valid", 32'(sel_valid),  32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_sel",   32'(sel),        32'd0);
    chk("abort_pm",    32'(pair_mask),  32'd0);
    chk("abort_last",  32'(last),       32'd0);
    chk("abort_ready", 32'(mask_ready), 32'd0);
    rst       = 1'b0;
    sel_ready = 1'b1;
    #1;
    chk("abort_ready_rise", 32'(mask_ready), 32'd1);
    repeat (2) begin
      step();
      chk("abort_no_valid", 32'(sel_valid), 32'd0);
      chk("abort_no_last",  32'(last),      32'd0);
    end
    sel_ready = 1'b0;

    for (int g = 0; g < 30; g++) begin
      run_group(NUM_IN'($urandom), int'($urandom_range(2, 0)), 2, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
